// File: rtl/serializer_frame_param.sv
// Frame serializer: snapshots NUM_WORDS x WORD_WIDTH bits on a valid/ready load
// and shifts them out one bit per enabled clock, with back-to-back frame support.
module serializer_frame_param #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 8,
    parameter int MSB_FIRST  = 0,
    parameter int IDLE_LEVEL = 0,
    localparam int BW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1,
    localparam int WW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            ENABLE,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] PAR_IN,
    input  logic                            LOAD_VALID,
    output logic                            LOAD_READY,
    output logic                            SERIAL_OUT,
    output logic                            SERIAL_VALID,
    output logic                            WORD_START,
    output logic                            FRAME_START,
    output logic                            FRAME_LAST,
    output logic [BW-1:0]                   BIT_COUNT,
    output logic [WW-1:0]                   WORD_COUNT
);

    localparam int   TOTAL    = NUM_WORDS * WORD_WIDTH;
    localparam int   IW       = $clog2(TOTAL);
    localparam logic IDLE_BIT = 1'(IDLE_LEVEL);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [TOTAL-1:0]   shadow;
    logic               accept;
    logic               last_bit;
    logic               last_word;
    logic [BW-1:0]      next_bit;
    logic [WW-1:0]      next_word;
    logic               next_serial;
    logic               first_serial;

    // Maps (word, send-order bit) to a flat position in the frame register.
    function automatic logic [IW-1:0] bit_index(input logic [WW-1:0] w, input logic [BW-1:0] b);
        int pos;
        pos = (MSB_FIRST != 0) ? (WORD_WIDTH - 1 - int'(b)) : int'(b);
        return IW'(int'(w) * WORD_WIDTH + pos);
    endfunction

    assign LOAD_READY = ENABLE && (state == IDLE || (state == SHIFT && FRAME_LAST));
    assign accept     = LOAD_VALID && LOAD_READY;

    always_comb begin
        last_bit     = (BIT_COUNT == BW'(WORD_WIDTH - 1));
        last_word    = (WORD_COUNT == WW'(NUM_WORDS - 1));
        next_bit     = last_bit ? '0 : BIT_COUNT + BW'(1);
        next_word    = WORD_COUNT;
        if (last_bit) begin
            next_word = last_word ? '0 : WORD_COUNT + WW'(1);
        end
        next_serial  = shadow[bit_index(next_word, next_bit)];
        first_serial = PAR_IN[bit_index('0, '0)];
    end

    // Flags are registered alongside the counters so they change on the same edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            shadow       <= '0;
            BIT_COUNT    <= '0;
            WORD_COUNT   <= '0;
            SERIAL_OUT   <= IDLE_BIT;
            SERIAL_VALID <= 1'b0;
            WORD_START   <= 1'b0;
            FRAME_START  <= 1'b0;
            FRAME_LAST   <= 1'b0;
        end else if (ENABLE) begin
            if (accept) begin
                shadow       <= PAR_IN;
                state        <= SHIFT;
                BIT_COUNT    <= '0;
                WORD_COUNT   <= '0;
                SERIAL_OUT   <= first_serial;
                SERIAL_VALID <= 1'b1;
                WORD_START   <= 1'b1;
                FRAME_START  <= 1'b1;
                FRAME_LAST   <= 1'b0;
            end else if (state == SHIFT) begin
                if (FRAME_LAST) begin
                    state        <= IDLE;
                    BIT_COUNT    <= '0;
                    WORD_COUNT   <= '0;
                    SERIAL_OUT   <= IDLE_BIT;
                    SERIAL_VALID <= 1'b0;
                    WORD_START   <= 1'b0;
                    FRAME_START  <= 1'b0;
                    FRAME_LAST   <= 1'b0;
                end else begin
                    BIT_COUNT    <= next_bit;
                    WORD_COUNT   <= next_word;
                    SERIAL_OUT   <= next_serial;
                    WORD_START   <= (next_bit == '0);
                    FRAME_START  <= (next_bit == '0) && (next_word == '0);
                    FRAME_LAST   <= (next_bit == BW'(WORD_WIDTH - 1)) &&
                                    (next_word == WW'(NUM_WORDS - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_serializer_frame_param.sv
// Directed bench for serializer_frame_param: 8x4 LSB/MSB-first instances plus a
// 2x1 instance, with table-driven frame checks and multi-cycle corner sequences.
module tb_serializer_frame_param;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [31:0] parIn;
    logic        loadValid;
    logic [1:0]  par2;
    logic        lv2;

    logic       ready0, ser0, sv0, ws0, fs0, fl0;
    logic [2:0] bc0;
    logic [1:0] wc0;
    logic       ready1, ser1, sv1, ws1, fs1, fl1;
    logic [2:0] bc1;
    logic [1:0] wc1;
    logic       ready2, ser2, sv2, ws2, fs2, fl2;
    logic       bc2;
    logic       wc2;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic       serLsb;
        logic       serMsb;
        logic       wstart;
        logic       fstart;
        logic       flast;
        logic [2:0] bcnt;
        logic [1:0] wcnt;
    } vec_t;

    vec_t vecs[2][32];

    always #5 CLK = ~CLK;

    serializer_frame_param #(.WORD_WIDTH(8), .NUM_WORDS(4), .MSB_FIRST(0), .IDLE_LEVEL(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PAR_IN(parIn), .LOAD_VALID(loadValid),
        .LOAD_READY(ready0), .SERIAL_OUT(ser0), .SERIAL_VALID(sv0), .WORD_START(ws0),
        .FRAME_START(fs0), .FRAME_LAST(fl0), .BIT_COUNT(bc0), .WORD_COUNT(wc0));

    serializer_frame_param #(.WORD_WIDTH(8), .NUM_WORDS(4), .MSB_FIRST(1), .IDLE_LEVEL(0)) dut1 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PAR_IN(parIn), .LOAD_VALID(loadValid),
        .LOAD_READY(ready1), .SERIAL_OUT(ser1), .SERIAL_VALID(sv1), .WORD_START(ws1),
        .FRAME_START(fs1), .FRAME_LAST(fl1), .BIT_COUNT(bc1), .WORD_COUNT(wc1));

    serializer_frame_param #(.WORD_WIDTH(2), .NUM_WORDS(1), .MSB_FIRST(0), .IDLE_LEVEL(0)) dut2 (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PAR_IN(par2), .LOAD_VALID(lv2),
        .LOAD_READY(ready2), .SERIAL_OUT(ser2), .SERIAL_VALID(sv2), .WORD_START(ws2),
        .FRAME_START(fs2), .FRAME_LAST(fl2), .BIT_COUNT(bc2), .WORD_COUNT(wc2));

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Offers a frame from idle and scrambles PAR_IN right after the accept edge.
    task automatic applyStimulus(input logic [31:0] data, input string tag);
        parIn = data;
        loadValid = 1'b1;
        checkOutput({tag, " ready before load"}, 64'(ready0), 64'(1));
        @(posedge CLK); #1;
        loadValid = 1'b0;
        parIn = 32'hDEAD_BEEF;
    endtask

    task automatic checkFrame(input int f, input bit checkMsb, input string tag);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("%s b%0d serial", tag, i), 64'(ser0), 64'(vecs[f][i].serLsb));
            if (checkMsb)
                checkOutput($sformatf("%s b%0d serial msb", tag, i), 64'(ser1), 64'(vecs[f][i].serMsb));
            checkOutput($sformatf("%s b%0d valid", tag, i), 64'(sv0), 64'(1));
            checkOutput($sformatf("%s b%0d word_start", tag, i), 64'(ws0), 64'(vecs[f][i].wstart));
            checkOutput($sformatf("%s b%0d frame_start", tag, i), 64'(fs0), 64'(vecs[f][i].fstart));
            checkOutput($sformatf("%s b%0d frame_last", tag, i), 64'(fl0), 64'(vecs[f][i].flast));
            checkOutput($sformatf("%s b%0d bit_count", tag, i), 64'(bc0), 64'(vecs[f][i].bcnt));
            checkOutput($sformatf("%s b%0d word_count", tag, i), 64'(wc0), 64'(vecs[f][i].wcnt));
            checkOutput($sformatf("%s b%0d ready", tag, i), 64'(ready0), 64'(vecs[f][i].flast));
            @(posedge CLK); #1;
        end
        checkOutput({tag, " valid after frame"}, 64'(sv0), 64'(0));
        checkOutput({tag, " idle level"}, 64'(ser0), 64'(0));
        checkOutput({tag, " ready after frame"}, 64'(ready0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [0:31] lsbA;
        logic [0:31] msbA;
        logic [0:31] lsbB;
        int cycles;

        lsbA = 32'b10000001_11110000_00111100_10100101;
        msbA = 32'b10000001_00001111_00111100_10100101;
        lsbB = 32'b00000000_00000000_11111111_11111111;
        for (int i = 0; i < 32; i++) begin
            vecs[0][i] = '{serLsb: lsbA[i], serMsb: msbA[i], wstart: (i % 8) == 0,
                           fstart: i == 0, flast: i == 31, bcnt: 3'(i % 8), wcnt: 2'(i / 8)};
            vecs[1][i] = '{serLsb: lsbB[i], serMsb: lsbB[i], wstart: (i % 8) == 0,
                           fstart: i == 0, flast: i == 31, bcnt: 3'(i % 8), wcnt: 2'(i / 8)};
        end

        RESET = 1'b1;
        ENABLE = 1'b0;
        parIn = '0;
        loadValid = 1'b0;
        par2 = '0;
        lv2 = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset serial", 64'(ser0), 64'(0));
        checkOutput("reset valid", 64'(sv0), 64'(0));
        checkOutput("reset flags", 64'({ws0, fs0, fl0}), 64'(0));
        checkOutput("reset counters", 64'({bc0, wc0}), 64'(0));
        checkOutput("ready with enable low", 64'(ready0), 64'(0));
        RESET = 1'b0;
        ENABLE = 1'b1;
        #1;
        checkOutput("ready idle", 64'(ready0), 64'(1));

        // Basic frame in both bit orders, with PAR_IN scrambled after accept.
        applyStimulus(32'hA53C_0F81, "frameA");
        checkFrame(0, 1'b1, "frameA");

        // Back-to-back: LOAD_VALID held across both frames.
        parIn = 32'hA53C_0F81;
        loadValid = 1'b1;
        @(posedge CLK); #1;
        parIn = 32'hFFFF_0000;
        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("b2b b%0d serial", i), 64'(ser0), 64'(vecs[i / 32][i % 32].serLsb));
            checkOutput($sformatf("b2b b%0d valid", i), 64'(sv0), 64'(1));
            checkOutput($sformatf("b2b b%0d frame_start", i), 64'(fs0), 64'((i % 32) == 0));
            checkOutput($sformatf("b2b b%0d ready", i), 64'(ready0), 64'((i % 32) == 31));
            if (i == 63) loadValid = 1'b0;
            @(posedge CLK); #1;
        end
        checkOutput("b2b valid after", 64'(sv0), 64'(0));

        // Stalls of 5 cycles at bit 13 and at the final bit.
        applyStimulus(32'hA53C_0F81, "stall");
        cycles = 0;
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("stall b%0d serial", i), 64'(ser0), 64'(vecs[0][i].serLsb));
            checkOutput($sformatf("stall b%0d bit_count", i), 64'(bc0), 64'(vecs[0][i].bcnt));
            cycles += int'(sv0);
            if (i == 13 || i == 31) begin
                ENABLE = 1'b0;
                repeat (5) begin
                    @(posedge CLK); #1;
                    checkOutput($sformatf("hold b%0d serial", i), 64'(ser0), 64'(vecs[0][i].serLsb));
                    checkOutput($sformatf("hold b%0d bit_count", i), 64'(bc0), 64'(vecs[0][i].bcnt));
                    checkOutput($sformatf("hold b%0d word_count", i), 64'(wc0), 64'(vecs[0][i].wcnt));
                    checkOutput($sformatf("hold b%0d frame_last", i), 64'(fl0), 64'(vecs[0][i].flast));
                    checkOutput($sformatf("hold b%0d ready", i), 64'(ready0), 64'(0));
                    cycles += int'(sv0);
                end
                ENABLE = 1'b1;
            end
            @(posedge CLK); #1;
        end
        checkOutput("stall valid after", 64'(sv0), 64'(0));
        checkOutput("stall frame time", 64'(cycles), 64'(42));

        // Asynchronous reset between edges while bit 17 is on the line.
        applyStimulus(32'hA53C_0F81, "rst");
        repeat (17) begin
            @(posedge CLK); #1;
        end
        checkOutput("pre-reset position", 64'({wc0, bc0}), 64'({2'd2, 3'd1}));
        #2 RESET = 1'b1;
        #1;
        checkOutput("async reset valid", 64'(sv0), 64'(0));
        checkOutput("async reset serial", 64'(ser0), 64'(0));
        checkOutput("async reset flags", 64'({ws0, fs0, fl0}), 64'(0));
        checkOutput("async reset counters", 64'({bc0, wc0}), 64'(0));
        #1 RESET = 1'b0;
        #1;
        checkOutput("ready after reset", 64'(ready0), 64'(1));
        applyStimulus(32'hFFFF_0000, "postrst");
        checkFrame(1, 1'b1, "postrst");

        // Single two-bit word frame.
        par2 = 2'b10;
        lv2 = 1'b1;
        checkOutput("w2 ready idle", 64'(ready2), 64'(1));
        @(posedge CLK); #1;
        lv2 = 1'b0;
        par2 = 2'b01;
        checkOutput("w2 b0 serial", 64'(ser2), 64'(0));
        checkOutput("w2 b0 starts", 64'({ws2, fs2, fl2}), 64'(3'b110));
        checkOutput("w2 b0 counters", 64'({bc2, wc2}), 64'(0));
        checkOutput("w2 b0 valid", 64'(sv2), 64'(1));
        @(posedge CLK); #1;
        checkOutput("w2 b1 serial", 64'(ser2), 64'(1));
        checkOutput("w2 b1 flags", 64'({ws2, fs2, fl2}), 64'(3'b001));
        checkOutput("w2 b1 counters", 64'({bc2, wc2}), 64'(2'b10));
        checkOutput("w2 b1 ready", 64'(ready2), 64'(1));
        @(posedge CLK); #1;
        checkOutput("w2 valid after", 64'(sv2), 64'(0));
        checkOutput("w2 last after", 64'(fl2), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serializer_frame_param.md
Name: serializer_frame_param

Overview:
- Parametrised successor to the fixed 8x32-bit serializer unit cell.
- Snapshots a frame of NUM_WORDS words of WORD_WIDTH bits through a valid/ready load handshake, then shifts the frame out one bit per enabled clock.
- Bit order is selectable. Frames can stream back-to-back with no idle bit between them, and ENABLE stalls the output.
- Sits between the parallel data source and the TX driver in the SERDES transmit path.

Parameters:
- WORD_WIDTH, 32: bits per word; legal range 2..64.
- NUM_WORDS, 8: words per frame; legal range 1..16.
- MSB_FIRST, 0: 0 sends bit 0 of each word first; 1 sends bit WORD_WIDTH-1 first.
- IDLE_LEVEL, 0: SERIAL_OUT value whenever no frame is active.

Ports:
- CLK  input  1  single clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  1 = advance one bit per clock; 0 = stall (hold all state).
- PAR_IN  input  NUM_WORDS*WORD_WIDTH  frame data; word k occupies [k*WORD_WIDTH +: WORD_WIDTH]; word 0 is sent first.
- LOAD_VALID  input  1  source offers PAR_IN.
- LOAD_READY  output  1  combinational; block accepts a frame this cycle.
- SERIAL_OUT  output  1  registered serial data.
- SERIAL_VALID  output  1  SERIAL_OUT carries a frame bit.
- WORD_START  output  1  high while the first bit of any word is on SERIAL_OUT.
- FRAME_START  output  1  high while bit 0 of word 0 is on SERIAL_OUT.
- FRAME_LAST  output  1  high while the final bit of the frame is on SERIAL_OUT.
- BIT_COUNT  output  max(1,$clog2(WORD_WIDTH))  index (in send order) of the bit currently on SERIAL_OUT.
- WORD_COUNT  output  max(1,$clog2(NUM_WORDS))  index of the word currently on SERIAL_OUT.

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - State = IDLE; shadow register = 0; counters = 0.
  - SERIAL_OUT = IDLE_LEVEL; SERIAL_VALID, WORD_START, FRAME_START, FRAME_LAST = 0.
  - An in-flight frame is discarded.
- States: IDLE, SHIFT.
- Accept = LOAD_VALID && LOAD_READY at a rising edge.
- LOAD_READY = ENABLE && (state==IDLE || (state==SHIFT && FRAME_LAST)).
- On accept:
  - PAR_IN is copied into the shadow register; later PAR_IN changes do not affect this frame.
  - State = SHIFT; counters = 0.
  - SERIAL_OUT = first bit of word 0 (bit 0, or bit WORD_WIDTH-1 if MSB_FIRST).
  - SERIAL_VALID = WORD_START = FRAME_START = 1.
  - Latency: accept edge to first bit on SERIAL_OUT is 1 clock.
- Each later rising edge in SHIFT with ENABLE=1:
  - BIT_COUNT increments.
  - At WORD_WIDTH-1, BIT_COUNT wraps to 0 and WORD_COUNT increments.
  - SERIAL_OUT takes the next bit from the shadow register.
  - WORD_START and FRAME_START are recomputed from the new counters.
- FRAME_LAST = 1 exactly when WORD_COUNT==NUM_WORDS-1 && BIT_COUNT==WORD_WIDTH-1 in SHIFT.
- Edge after the final bit with ENABLE=1:
  - If accept also occurs (back-to-back): the new frame's first bit follows immediately, with FRAME_START=1, and SERIAL_VALID stays 1.
  - Otherwise: state = IDLE, SERIAL_OUT = IDLE_LEVEL, SERIAL_VALID = 0.
- ENABLE=0: state, counters, SERIAL_OUT and all flags hold their value; LOAD_READY=0. Stalls may last any length and may fall at any bit, including the final one.
- Frame length = NUM_WORDS*WORD_WIDTH enabled clocks, from the first bit up to and including FRAME_LAST.
- NUM_WORDS=1: WORD_COUNT stays 0; WORD_START and FRAME_START coincide.
- LOAD_VALID high while LOAD_READY=0: no effect; the source must hold it. The block never drops or duplicates a frame.
- No X on any output after reset, for all legal parameter values.

Test Plan:
- WORD_WIDTH=8, NUM_WORDS=4, MSB_FIRST=0; load PAR_IN=32'hA5_3C_0F_81 with ENABLE=1.
  - Required: SERIAL_OUT sequence is 1,0,0,0,0,0,0,1 then 1,1,1,1,0,0,0,0 then 0,0,1,1,1,1,0,0 then 1,0,1,0,0,1,0,1.
  - WORD_START on bits 0/8/16/24; FRAME_LAST on bit 31; SERIAL_VALID drops on the next edge.
- Same data with MSB_FIRST=1.
  - Required: first word is 1,0,0,0,0,0,0,1 (0x81 MSB-first); word 1 (0x0F) is 0,0,0,0,1,1,1,1.
- Back-to-back: hold LOAD_VALID=1 with a second frame 32'hFFFF0000.
  - Required: LOAD_READY=1 only on the FRAME_LAST cycle.
  - 64 consecutive SERIAL_VALID cycles; FRAME_START at bits 0 and 32.
- Stall: drop ENABLE for 5 cycles at bit 13 and again at bit 31.
  - Required: SERIAL_OUT, BIT_COUNT=5, WORD_COUNT=1 and FRAME_LAST hold their values.
  - Output sequence equals the unstalled sequence; total frame time is 42 cycles.
- Reset mid-frame: assert RESET asynchronously at bit 17, between clock edges.
  - Required: outputs go to reset values immediately; LOAD_READY=1 after RESET deasserts with ENABLE=1; the next frame starts cleanly.
- Load isolation and NUM_WORDS=1.
  - Change PAR_IN after accept: the sent data is unchanged.
  - With NUM_WORDS=1, WORD_WIDTH=2: frame length is 2; FRAME_START and FRAME_LAST are on consecutive cycles.
